// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the PC, issues in-order imem reads, buffers {pc, instr}
// pairs for decode and drops stale in-flight responses after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_resp_valid_i,
    input  logic [31:0] imem_resp_data_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   buf_pc_r    [FIFO_DEPTH];
    logic [31:0]   buf_instr_r [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] occ_r;
    logic [31:0]   ifq_pc_r [MAX_OUTSTANDING];
    logic [QW-1:0] ifq_rd_r;
    logic [QW-1:0] ifq_wr_r;
    logic [OW-1:0] outstanding_r;
    logic [OW-1:0] discard_r;
    logic [OW-1:0] discard_s;
    logic [OW-1:0] live_s;
    logic [31:0]   used_s;
    logic          req_valid_s;
    logic          issue_s;
    logic          keep_s;
    logic          pop_s;
    logic          unused_s;

    function automatic logic [QW-1:0] ifq_next(input logic [QW-1:0] ptr);
        logic [QW-1:0] nxt;
        if (ptr == QW'(MAX_OUTSTANDING - 1)) begin
            nxt = QW'(0);
        end else begin
            nxt = ptr + QW'(1);
        end
        return nxt;
    endfunction

    // Credit: buffered entries plus responses still destined for the buffer must fit.
    assign live_s      = outstanding_r - discard_r;
    assign used_s      = 32'(occ_r) + 32'(live_s);
    assign req_valid_s = !rst_i && !jump_i
                         && (32'(outstanding_r) < 32'(MAX_OUTSTANDING))
                         && (used_s < 32'(FIFO_DEPTH));
    assign issue_s     = req_valid_s && imem_req_ready_i;
    assign keep_s      = imem_resp_valid_i && !jump_i && (state_r == ST_RUN);
    assign pop_s       = (occ_r != CW'(0)) && !stall_i && !jump_i;
    assign unused_s    = ^jump_addr_i[1:0];

    assign imem_req_valid_o = req_valid_s;
    assign imem_addr_o      = fetch_pc_r;
    assign valid_o          = (occ_r != CW'(0));
    assign pc_o             = valid_o ? buf_pc_r[rd_ptr_r] : 32'h0000_0000;
    assign instr_o          = valid_o ? buf_instr_r[rd_ptr_r] : NOP;

    // Next discard count and RUN/DRAIN state.
    always_comb begin
        discard_s = discard_r;
        state_s   = state_r;
        if (jump_i) begin
            // A response landing in the jump cycle is already accounted for and dropped.
            discard_s = outstanding_r - OW'(imem_resp_valid_i);
        end else if (imem_resp_valid_i && (discard_r != OW'(0))) begin
            discard_s = discard_r - OW'(1);
        end else begin
            discard_s = discard_r;
        end
        case (state_r)
            ST_RUN: begin
                if (discard_s != OW'(0)) state_s = ST_DRAIN;
                else                     state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (discard_s == OW'(0)) state_s = ST_RUN;
                else                     state_s = ST_DRAIN;
            end
            default: state_s = ST_RUN;
        endcase
    end

    // State and discard count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_RUN;
            discard_r <= OW'(0);
        end else begin
            state_r   <= state_s;
            discard_r <= discard_s;
        end
    end

    // PC, outstanding count and in-flight PC queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_r    <= RESET_PC;
            outstanding_r <= OW'(0);
            ifq_rd_r      <= QW'(0);
            ifq_wr_r      <= QW'(0);
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                ifq_pc_r[i] <= 32'h0000_0000;
            end
        end else begin
            if (jump_i) begin
                fetch_pc_r <= {jump_addr_i[31:2], 2'b00};
            end else if (issue_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            outstanding_r <= outstanding_r + OW'(issue_s) - OW'(imem_resp_valid_i);
            if (issue_s) begin
                ifq_pc_r[ifq_wr_r] <= fetch_pc_r;
                ifq_wr_r           <= ifq_next(ifq_wr_r);
            end
            if (imem_resp_valid_i) begin
                ifq_rd_r <= ifq_next(ifq_rd_r);
            end
        end
    end

    // {pc, instr} buffer; a redirect flushes it without popping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            occ_r    <= CW'(0);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_pc_r[i]    <= 32'h0000_0000;
                buf_instr_r[i] <= NOP;
            end
        end else if (jump_i) begin
            rd_ptr_r <= PW'(0);
            wr_ptr_r <= PW'(0);
            occ_r    <= CW'(0);
        end else begin
            if (keep_s) begin
                buf_pc_r[wr_ptr_r]    <= ifq_pc_r[ifq_rd_r];
                buf_instr_r[wr_ptr_r] <= imem_resp_data_i;
                wr_ptr_r              <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            occ_r <= occ_r + CW'(keep_s) - CW'(pop_s);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural imem with random latency/ready and an
// epoch-tagged reference model of the fetch stream, buffer occupancy and request credit.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;
    localparam int          MAXO   = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = 32'h0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .jump_i(jump_i),
        .jump_addr_i(jump_addr_i), .imem_req_valid_o(imem_req_valid_o),
        .imem_req_ready_i(imem_req_ready_i), .imem_addr_o(imem_addr_o),
        .imem_resp_valid_i(imem_resp_valid_i), .imem_resp_data_i(imem_resp_data_i),
        .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // imem model and reference state
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          mq_epoch[$];
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          occ = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    bit          hs_seen;
    logic [31:0] hs_addr;
    bit          pop_seen;
    logic [31:0] pop_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mq_epoch[i]) if (mq_epoch[i] == epoch) n++;
        return n;
    endfunction

    task automatic model_reset();
        mq_addr.delete(); mq_due.delete(); mq_epoch.delete();
        occ = 0; epoch++; last_due = cyc;
        exp_fetch = RST_PC; exp_pc = RST_PC; prev_hold = 1'b0;
    endtask

    // One clock cycle: drive, check settled outputs, clock, advance the model.
    task automatic tick(input bit s, input bit j, input logic [31:0] ja, input bit rdy, input bit r);
        bit hs, pop, keep, exp_req;
        int due;
        rst_i = r; stall_i = s; jump_i = j; jump_addr_i = ja; imem_req_ready_i = rdy;
        if (!r && mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_resp_valid_i = 1'b1; imem_resp_data_i = mem_word(mq_addr[0]);
        end else begin
            imem_resp_valid_i = 1'b0; imem_resp_data_i = $urandom;
        end
        #1;
        exp_req = !r && !j && (mq_addr.size() < MAXO) && (occ + live_cnt() < DEPTH);
        n_tests++;
        if (imem_req_valid_o !== exp_req) begin
            n_fail++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid_o, exp_req);
        end
        hs = imem_req_valid_o && rdy;
        if (hs) begin
            n_tests++;
            if (imem_addr_o !== exp_fetch) begin
                n_fail++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_addr_o, exp_fetch);
            end
        end
        n_tests++;
        if (valid_o !== (occ != 0)) begin
            n_fail++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid_o, occ != 0);
        end
        if (valid_o === 1'b0) begin
            n_tests++;
            if (pc_o !== 32'h0 || instr_o !== NOP) begin
                n_fail++; $display("FAIL empty_out cyc=%0d got=%h/%h exp=0/%h", cyc, pc_o, instr_o, NOP);
            end
        end
        if (prev_hold) begin
            n_tests++;
            if (valid_o !== 1'b1 || pc_o !== prev_pc || instr_o !== prev_instr) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_o, instr_o, prev_pc, prev_instr);
            end
        end
        pop = valid_o && !s && !j && !r;
        if (pop) begin
            n_tests++;
            if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
                n_fail++; $display("FAIL pop cyc=%0d got=%h/%h exp=%h/%h", cyc, pc_o, instr_o, exp_pc, mem_word(exp_pc));
            end
        end
        if (hs && mq_addr.size() >= MAXO) begin
            n_tests++; n_fail++;
            $display("FAIL outstanding cyc=%0d got=%0d exp<%0d", cyc, mq_addr.size() + 1, MAXO + 1);
        end
        hs_seen = hs; hs_addr = imem_addr_o; pop_seen = pop; pop_pc = pc_o;
        prev_hold = valid_o && s && !j && !r; prev_pc = pc_o; prev_instr = instr_o;
        @(posedge clk); #1;
        if (r) begin
            model_reset();
        end else begin
            keep = 1'b0;
            if (imem_resp_valid_i) begin
                keep = !j && (mq_epoch[0] == epoch);
                mq_addr.delete(0); mq_due.delete(0); mq_epoch.delete(0);
            end
            occ = occ + int'(keep) - int'(pop);
            if (pop) exp_pc = exp_pc + 32'd4;
            if (j) begin
                occ = 0; epoch++;
                exp_fetch = {ja[31:2], 2'b00}; exp_pc = {ja[31:2], 2'b00};
            end
            if (hs) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq_addr.push_back(exp_fetch); mq_due.push_back(due); mq_epoch.push_back(epoch);
                exp_fetch = exp_fetch + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; imem_req_ready_i = 1'b1;
        @(posedge clk); #1;
        cyc++; model_reset();
        n_tests++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== NOP || imem_addr_o !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_state got=%b/%h/%h/%h exp=0/0/%h/%h", valid_o, pc_o, instr_o, imem_addr_o, NOP, RST_PC);
        end
    endtask

    task automatic test_latency();
        int first = 0;
        lat_min = 1; lat_max = 1;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            if (valid_o === 1'b1 && first == 0) first = k;
            tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        n_tests++;
        if (first != 3) begin
            n_fail++; $display("FAIL first_valid got=%0d exp=3", first);
        end
    endtask

    task automatic test_stall();
        lat_min = 1; lat_max = 1;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        run(6);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        n_tests++;
        if (imem_req_valid_o !== 1'b0 || valid_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_credit got=%b/%b exp=0/1", imem_req_valid_o, valid_o);
        end
        run(20);
    endtask

    task automatic test_jump_drain();
        logic [31:0] got[$];
        lat_min = 3; lat_max = 3;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && mq_addr.size() != 2; i++) run(1);
        n_tests++;
        if (mq_addr.size() != 2) begin
            n_fail++; $display("FAIL drain_setup got=%0d exp=2", mq_addr.size());
        end
        tick(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
        for (int i = 0; i < 30 && got.size() < 2; i++) begin
            run(1);
            if (pop_seen) got.push_back(pop_pc);
        end
        n_tests++;
        if (got.size() != 2 || got[0] !== 32'h100 || got[1] !== 32'h104) begin
            n_fail++; $display("FAIL jump_stream got_n=%0d exp=100,104", got.size());
        end
    endtask

    task automatic test_jump_resp();
        bit seen = 1'b0;
        lat_min = 1; lat_max = 1;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && !(mq_due.size() == 1 && mq_due[0] == cyc); i++) run(1);
        n_tests++;
        if (!(mq_due.size() == 1 && mq_due[0] == cyc)) begin
            n_fail++; $display("FAIL jresp_setup got=%0d exp=1", mq_due.size());
        end
        tick(1'b0, 1'b1, 32'h0000_0203, 1'b1, 1'b0);
        n_tests++;
        if (imem_addr_o !== 32'h200) begin
            n_fail++; $display("FAIL jresp_addr got=%h exp=00000200", imem_addr_o);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            run(1);
            if (pop_seen) begin
                seen = 1'b1; n_tests++;
                if (pop_pc !== 32'h200) begin
                    n_fail++; $display("FAIL jresp_first got=%h exp=00000200", pop_pc);
                end
            end
        end
        if (!seen) begin
            n_tests++; n_fail++; $display("FAIL jresp_timeout got=none exp=00000200");
        end
    endtask

    task automatic test_wrap();
        logic [31:0] got[$];
        lat_min = 1; lat_max = 1;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 15 && got.size() < 3; i++) begin
            run(1);
            if (hs_seen) got.push_back(hs_addr);
        end
        n_tests++;
        if (got.size() != 3 || got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addrs got_n=%0d exp=FFFFFFF8,FFFFFFFC,00000000", got.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        bit seen = 1'b0;
        lat_min = 3; lat_max = 3;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10 && mq_addr.size() != 2; i++) run(1);
        tick(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        n_tests++;
        if (valid_o !== 1'b0 || pc_o !== 32'h0 || instr_o !== NOP || imem_addr_o !== RST_PC) begin
            n_fail++; $display("FAIL drain_reset got=%b/%h/%h/%h exp=0/0/%h/%h", valid_o, pc_o, instr_o, imem_addr_o, NOP, RST_PC);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            run(1);
            if (pop_seen) begin
                seen = 1'b1; n_tests++;
                if (pop_pc !== RST_PC) begin
                    n_fail++; $display("FAIL drain_restart got=%h exp=%h", pop_pc, RST_PC);
                end
            end
        end
        if (!seen) begin
            n_tests++; n_fail++; $display("FAIL drain_restart_timeout got=none exp=%h", RST_PC);
        end
    endtask

    task automatic test_random();
        bit r, j;
        lat_min = 1; lat_max = 4;
        tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(999, 0) < 2);
            j = !r && ($urandom_range(99, 0) < 4);
            tick($urandom_range(99, 0) < 30, j, $urandom, $urandom_range(99, 0) < 75, r);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_stall();
        test_jump_drain();
        test_jump_resp();
        test_wrap();
        test_reset_mid_drain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
